// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared signed multiplier/accumulator stepped over N_TAPS taps per sample.
// Latency: sample accepted at edge t, y_valid high after edge t+N_TAPS, y_out registered at edge t+N_TAPS+1.
// Backpressure: in_ready is low in MAC/DONE and while coef_load is pending in IDLE; one sample per N_TAPS+2 cycles.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   coef_load         request coefficient reload (honoured in IDLE only)
//   in_data/in_valid  coefficient (LOAD) or sample (IDLE) stream
//   in_ready          combinational accept indication
//   y_out/y_valid     filtered result (held) and its one-cycle pulse
//   busy              high while the MAC sequence or result write is in progress
//   sat_flag          present only with FIR_SAT_OUT_EN: result was clamped
//
// Build option: define FIR_SAT_OUT_EN to saturate y_out instead of wrapping it.

module fir_mac_sequencer #(
  parameter int N_TAPS     = 3,
  parameter int BW_in      = 6,
  parameter int BW_product = 12,
  parameter int BW_sum     = 14,
  parameter int BW_out     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    coef_load,
  input  logic signed [BW_in-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [BW_out-1:0]       y_out,
  output logic                    y_valid,
`ifdef FIR_SAT_OUT_EN
  output logic                    busy,
  output logic                    sat_flag
`else
  output logic                    busy
`endif
);

  localparam int KW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_TAPS - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_MAC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [BW_in-1:0]  r_c [N_TAPS];
  logic signed [BW_in-1:0]  r_x [N_TAPS];
  logic [KW-1:0]            r_load_cnt;
  logic [KW-1:0]            r_k;
  logic signed [BW_sum-1:0] r_acc;
  logic [BW_out-1:0]        r_y_out;

  logic                     w_accept;
  logic signed [BW_in-1:0]  w_x_sel;
  logic signed [BW_in-1:0]  w_c_sel;
  logic signed [BW_product-1:0] w_prod;
  logic signed [BW_sum-1:0] w_prod_ext;
  logic [BW_out-1:0]        w_y_nxt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_accept && (r_load_cnt == K_LAST)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        // coef_load has priority: a same-cycle sample is refused via in_ready.
        if (coef_load) begin
          w_state_nxt = S_LOAD;
        end else if (w_accept) begin
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        if (r_k == K_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    y_valid  = 1'b0;
    case (r_state)
      S_LOAD: in_ready = 1'b1;
      S_IDLE: in_ready = !coef_load;
      S_MAC:  busy     = 1'b1;
      S_DONE: begin
        busy    = 1'b1;
        y_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Shared MAC datapath: tap k of the delay line times coefficient k
  // ---------------------------------------------------------------------------
  assign w_x_sel    = r_x[r_k];
  assign w_c_sel    = r_c[r_k];
  assign w_prod     = BW_product'(w_x_sel) * BW_product'(w_c_sel);
  assign w_prod_ext = BW_sum'(w_prod);

`ifdef FIR_SAT_OUT_EN
  localparam logic signed [BW_sum-1:0] SAT_MAX = BW_sum'((2 ** (BW_out - 1)) - 1);
  localparam logic signed [BW_sum-1:0] SAT_MIN = ~SAT_MAX;

  logic w_sat_nxt;
  logic r_sat_flag;

  always_comb begin
    w_y_nxt   = r_acc[BW_out-1:0];
    w_sat_nxt = 1'b0;
    if (r_acc > SAT_MAX) begin
      w_y_nxt   = SAT_MAX[BW_out-1:0];
      w_sat_nxt = 1'b1;
    end else if (r_acc < SAT_MIN) begin
      w_y_nxt   = SAT_MIN[BW_out-1:0];
      w_sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_flag <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_sat_flag <= w_sat_nxt;
    end
  end

  assign sat_flag = r_sat_flag;
`else
  assign w_y_nxt = r_acc[BW_out-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Coefficients, delay line, counters, accumulator and result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_c[i] <= '0;
        r_x[i] <= '0;
      end
      r_load_cnt <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_y_out    <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          // First-loaded coefficient ends up in c[N_TAPS-1].
          if (w_accept) begin
            for (int i = N_TAPS - 1; i > 0; i--) begin
              r_c[i] <= r_c[i-1];
            end
            r_c[0] <= in_data;
            if (r_load_cnt == K_LAST) begin
              r_load_cnt <= '0;
            end else begin
              r_load_cnt <= r_load_cnt + KW'(1);
            end
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            for (int i = N_TAPS - 1; i > 0; i--) begin
              r_x[i] <= r_x[i-1];
            end
            r_x[0] <= in_data;
            r_acc  <= '0;
            r_k    <= '0;
          end
        end
        S_MAC: begin
          // Accumulator wraps modulo 2^BW_sum by construction.
          r_acc <= r_acc + w_prod_ext;
          if (r_k == K_LAST) begin
            r_k <= '0;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          r_y_out <= w_y_nxt;
        end
        default: begin
          r_k <= '0;
        end
      endcase
    end
  end

  assign y_out = r_y_out;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (default parameters).
// Expected results are hand-computed from the coefficient/sample sequences.
// Works with or without FIR_SAT_OUT_EN defined.

module tb_fir_mac_sequencer;

  localparam int N_TAPS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       coef_load;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y_out;
  logic       y_valid;
  logic       busy;
`ifdef FIR_SAT_OUT_EN
  logic       sat_flag;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  fir_mac_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .coef_load (coef_load),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_out     (y_out),
    .y_valid   (y_valid),
`ifdef FIR_SAT_OUT_EN
    .busy      (busy),
    .sat_flag  (sat_flag)
`else
    .busy      (busy)
`endif
  );

  always #5 clk = ~clk;

  // Count every y_valid cycle, sampled away from the active edge.
  always @(negedge clk) begin
    if (y_valid === 1'b1) pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coef(input logic [5:0] v);
    coef_load = 1'b0;
    in_data   = v;
    in_valid  = 1'b1;
    #1;
    check("load_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Push one sample and follow it through MAC and DONE.
  task automatic run_sample(input string tag, input logic [5:0] v,
                            input logic [7:0] exp_wrap, input logic [7:0] exp_sat,
                            input logic exp_flag);
    int cyc;
    coef_load = 1'b0;
    in_data   = v;
    in_valid  = 1'b1;
    #1;
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_mac_busy"},  {31'd0, busy},     32'd1);
    check({tag, "_mac_ready"}, {31'd0, in_ready}, 32'd0);
    cyc = 0;
    while (y_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, N_TAPS);
    check({tag, "_done_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_done_busy"},  {31'd0, busy},     32'd1);
    tick();
    check({tag, "_valid_fall"}, {31'd0, y_valid}, 32'd0);
    check({tag, "_idle_busy"},  {31'd0, busy},    32'd0);
`ifdef FIR_SAT_OUT_EN
    check({tag, "_y"},    {24'd0, y_out},    {24'd0, exp_sat});
    check({tag, "_flag"}, {31'd0, sat_flag}, {31'd0, exp_flag});
`else
    check({tag, "_y"}, {24'd0, y_out}, {24'd0, exp_wrap});
`endif
  endtask

  initial begin
    reset     = 1'b1;
    coef_load = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    tick();
    tick();
    check("rst_y",     {24'd0, y_out},    32'd0);
    check("rst_valid", {31'd0, y_valid},  32'd0);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
`ifdef FIR_SAT_OUT_EN
    check("rst_flag",  {31'd0, sat_flag}, 32'd0);
`endif
    reset = 1'b0;

    // Coefs 1,2,3 -> c2=1 c1=2 c0=3; impulse response 3,2,1,0.
    load_coef(6'd1);
    load_coef(6'd2);
    load_coef(6'd3);
    run_sample("imp0", 6'd1, 8'd3, 8'd3, 1'b0);
    run_sample("imp1", 6'd0, 8'd2, 8'd2, 1'b0);
    run_sample("imp2", 6'd0, 8'd1, 8'd1, 1'b0);
    run_sample("imp3", 6'd0, 8'd0, 8'd0, 1'b0);

    // Step response 3,5,6.
    run_sample("step0", 6'd1, 8'd3, 8'd3, 1'b0);
    run_sample("step1", 6'd1, 8'd5, 8'd5, 1'b0);
    run_sample("step2", 6'd1, 8'd6, 8'd6, 1'b0);

    // Idle with in_valid low for 10 cycles: nothing moves.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_hold_valid", {31'd0, y_valid}, 32'd0);
      check("idle_hold_busy",  {31'd0, busy},    32'd0);
    end
    // x = [0,1,1] -> 2*1 + 1*1 = 3
    run_sample("after_idle", 6'd0, 8'd3, 8'd3, 1'b0);

    // coef_load with a same-cycle sample: sample refused, enter LOAD.
    coef_load = 1'b1;
    in_valid  = 1'b1;
    in_data   = 6'd5;
    #1;
    check("cl_ready", {31'd0, in_ready}, 32'd0);
    tick();
    coef_load = 1'b0;
    in_valid  = 1'b0;
    // LOAD with in_valid low for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("load_hold_valid", {31'd0, y_valid},  32'd0);
      check("load_hold_ready", {31'd0, in_ready}, 32'd1);
    end
    // New coefs 2,0,1 -> c2=2 c1=0 c0=1; delay line still [0,0,1] after sample 0 -> 2.
    load_coef(6'd2);
    load_coef(6'd0);
    load_coef(6'd1);
    run_sample("reload", 6'd0, 8'd2, 8'd2, 1'b0);

    // Reset during the second MAC cycle: result lost, everything cleared.
    in_data  = 6'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("abort_valid", {31'd0, y_valid}, 32'd0);
      tick();
    end
    check("abort_y",     {24'd0, y_out},    32'd0);
    check("abort_busy",  {31'd0, busy},     32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);

    // Next inputs are coefficients: all -32; delay line cleared by reset.
    load_coef(6'h20);
    load_coef(6'h20);
    load_coef(6'h20);
    run_sample("sat_pos0", 6'h20, 8'h00, 8'h7F, 1'b1);  // acc = 1024
    run_sample("sat_pos1", 6'h01, 8'hE0, 8'h7F, 1'b1);  // acc = 992
    run_sample("sat_pos2", 6'h01, 8'hC0, 8'h7F, 1'b1);  // acc = 960
    run_sample("sat_neg",  6'h1F, 8'hE0, 8'h80, 1'b1);  // acc = -1056

    tick();
    check("pulse_count", pulses, 13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
